// File: rtl/mem_run_sequencer_if.sv
// Bundles the host, CPU and data-RAM buses that meet at the run sequencer.
// Latency: none (wires only).
// Backpressure: host_gnt is the only stall signal; the CPU and RAM sides never stall.
//
// Modports:
//   slave  - the sequencer: takes host/CPU requests and RAM read data, drives grants and the RAM bus.
//   master - the surroundings: host, CPU core and data RAM as seen from outside the sequencer.
interface mem_run_sequencer_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  // host port
  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic [DATA_W-1:0] host_rdata;
  logic              host_gnt;

  // CPU datapath RAM port and run control
  logic              cpu_init;
  logic              cpu_halt;
  logic              cpu_ren;
  logic              cpu_wen;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;

  // data RAM (combinational read, write on the clock edge)
  logic              ram_ren;
  logic              ram_wen;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  host_req, host_we, host_addr, host_wdata,
    output host_rdata, host_gnt,
    output cpu_init, cpu_rdata,
    input  cpu_halt, cpu_ren, cpu_wen, cpu_addr, cpu_wdata,
    output ram_ren, ram_wen, ram_addr, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output host_req, host_we, host_addr, host_wdata,
    input  host_rdata, host_gnt,
    input  cpu_init, cpu_rdata,
    output cpu_halt, cpu_ren, cpu_wen, cpu_addr, cpu_wdata,
    input  ram_ren, ram_wen, ram_addr, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/mem_run_sequencer.sv
// Sequences one CPU program run and muxes the shared data RAM between host and CPU.
// Latency: go to first RUN cycle is 2 cycles, or 2^ADDR_W+2 with RUN_CLEAR_EN (RAM clear pass).
// Backpressure: host only gets the RAM in IDLE/DONE and never in a go cycle; CPU is never stalled.
//
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   go           - start a run (honoured in IDLE/DONE only, wins over a host request)
//   bus          - host / CPU / RAM buses (mem_run_sequencer_if.slave)
//   busy, done   - busy in CLEAR/START/RUN, done in DONE
//   timeout      - last run was stopped by the watchdog
//   cycle_count  - RUN cycles of the last or current run
//
// Build option: define RUN_CLEAR_EN to zero the whole RAM before every run.
module mem_run_sequencer #(
  parameter int               ADDR_W  = 8,
  parameter int               DATA_W  = 8,
  parameter int               CNT_W   = 16,
  parameter logic [CNT_W-1:0] TIMEOUT = 16'hFFFF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                go,
  mem_run_sequencer_if.slave  bus,
  output logic                busy,
  output logic                done,
  output logic                timeout,
  output logic [CNT_W-1:0]    cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
`ifdef RUN_CLEAR_EN
    S_CLEAR = 3'd1,
`endif
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Watchdog fires when the count reaches TIMEOUT-1 on a non-halting cycle,
  // so a watchdog stop leaves cycle_count one below the number of RUN cycles.
  localparam logic [CNT_W-1:0] WD_LAST = TIMEOUT - 1'b1;

  state_t            state;
  logic              cpu_init_q;
  logic              host_gnt;
`ifdef RUN_CLEAR_EN
  logic [ADDR_W-1:0] clr_cnt;
`endif

  logic              mux_ren;
  logic              mux_wen;
  logic [ADDR_W-1:0] mux_addr;
  logic [DATA_W-1:0] mux_wdata;

  // go in the same cycle steals the RAM from the host.
  assign host_gnt = ((state == S_IDLE) || (state == S_DONE)) && bus.host_req && !go;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cpu_init_q  <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      cycle_count <= '0;
`ifdef RUN_CLEAR_EN
      clr_cnt     <= '0;
`endif
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (go) begin
            done <= 1'b0;
            busy <= 1'b1;
`ifdef RUN_CLEAR_EN
            clr_cnt <= '0;
            state   <= S_CLEAR;
`else
            state   <= S_START;
`endif
          end
        end
`ifdef RUN_CLEAR_EN
        S_CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;  // wraps back to 0 on the last address
          if (clr_cnt == '1) begin
            state <= S_START;
          end
        end
`endif
        S_START: begin
          cycle_count <= '0;
          timeout     <= 1'b0;
          cpu_init_q  <= 1'b0;
          state       <= S_RUN;
        end
        S_RUN: begin
          // halt is checked first so a halt on the watchdog cycle is a clean finish
          if (bus.cpu_halt) begin
            cycle_count <= cycle_count + 1'b1;
            timeout     <= 1'b0;
            done        <= 1'b1;
            busy        <= 1'b0;
            cpu_init_q  <= 1'b1;
            state       <= S_DONE;
          end else if (cycle_count == WD_LAST) begin
            timeout     <= 1'b1;
            done        <= 1'b1;
            busy        <= 1'b0;
            cpu_init_q  <= 1'b1;
            state       <= S_DONE;
          end else begin
            cycle_count <= cycle_count + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // RAM owner is purely a function of state; everything not selected drives 0.
  always_comb begin
    mux_ren   = 1'b0;
    mux_wen   = 1'b0;
    mux_addr  = '0;
    mux_wdata = '0;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (host_gnt) begin
          mux_ren   = !bus.host_we;
          mux_wen   = bus.host_we;
          mux_addr  = bus.host_addr;
          mux_wdata = bus.host_wdata;
        end
      end
`ifdef RUN_CLEAR_EN
      S_CLEAR: begin
        mux_wen  = 1'b1;
        mux_addr = clr_cnt;
      end
`endif
      S_RUN: begin
        mux_ren   = bus.cpu_ren;
        mux_wen   = bus.cpu_wen;
        mux_addr  = bus.cpu_addr;
        mux_wdata = bus.cpu_wdata;
      end
      default: begin
      end
    endcase
  end

  assign bus.ram_ren    = mux_ren;
  assign bus.ram_wen    = mux_wen;
  assign bus.ram_addr   = mux_addr;
  assign bus.ram_wdata  = mux_wdata;
  assign bus.host_gnt   = host_gnt;
  assign bus.host_rdata = bus.ram_rdata;
  assign bus.cpu_rdata  = bus.ram_rdata;
  assign bus.cpu_init   = cpu_init_q;

endmodule

// File: tb/tb_mem_run_sequencer.sv
`timescale 1ns/1ps
module tb_mem_run_sequencer;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int CW = 16;
  localparam logic [CW-1:0] TO = 16'd20;
`ifdef RUN_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif
  localparam int DEPTH = 1 << AW;
  localparam int LAT   = CLR ? DEPTH + 2 : 2;  // go edge to first RUN cycle

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          go = 1'b0;
  logic          busy, done, timeout;
  logic [CW-1:0] cycle_count;

  mem_run_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_run_sequencer #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .bus(bus),
    .busy(busy), .done(done), .timeout(timeout), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- data RAM ----------------
  logic [DW-1:0] ram [DEPTH];
  always @(posedge clk) if (bus.ram_wen) ram[bus.ram_addr] <= bus.ram_wdata;
  assign bus.ram_rdata = ram[bus.ram_addr];

  // ---------------- toy CPU ----------------
  // writes 3C to 02 on its 2nd run cycle, reads 10 on its 3rd, halts on cycle halt_at (0 = never)
  int   halt_at   = 0;
  logic cpu_force = 1'b0;  // asserts a CPU write while the core is not running
  int   cpu_cyc   = 0;
  always @(posedge clk) cpu_cyc <= bus.cpu_init ? 0 : cpu_cyc + 1;
  assign bus.cpu_halt  = !bus.cpu_init && (halt_at != 0) && (cpu_cyc == halt_at - 1);
  assign bus.cpu_wen   = (!bus.cpu_init && cpu_cyc == 1) || cpu_force;
  assign bus.cpu_ren   = !bus.cpu_init && cpu_cyc == 2;
  assign bus.cpu_addr  = (cpu_cyc == 2) ? 8'h10 : 8'h02;
  assign bus.cpu_wdata = cpu_force ? 8'h77 : 8'h3C;

  // ---------------- reference model ----------------
  // m_t counts cycles since go was accepted; phases follow from it arithmetically.
  bit          m_active = 0, m_done = 0, m_to = 0;
  int          m_t = 0, m_cnt = 0;
  bit [DW-1:0] mm [DEPTH];
  bit          mv [DEPTH];

  always @(negedge clk) begin : cmp
    bit            ph_clr, ph_run, gnt;
    int            k;
    logic          e_ren, e_wen;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    if (!rst_n) begin
      m_active = 0; m_done = 0; m_to = 0; m_cnt = 0; m_t = 0;
    end
    ph_clr = m_active && CLR && (m_t < DEPTH);
    ph_run = m_active && (m_t >= LAT - 1);
    k      = m_t - (LAT - 1) + 1;  // 1-based RUN cycle number
    gnt    = !m_active && bus.host_req && !go;
    e_ren = 1'b0; e_wen = 1'b0; e_addr = '0; e_wdata = '0;
    if (gnt) begin
      e_ren = !bus.host_we; e_wen = bus.host_we; e_addr = bus.host_addr; e_wdata = bus.host_wdata;
    end else if (ph_clr) begin
      e_wen = 1'b1; e_addr = AW'(m_t);
    end else if (ph_run) begin
      e_ren = bus.cpu_ren; e_wen = bus.cpu_wen; e_addr = bus.cpu_addr; e_wdata = bus.cpu_wdata;
    end
    check("cpu_init", bus.cpu_init, !ph_run);
    check("busy", busy, m_active);
    check("done", done, !m_active && m_done);
    check("timeout", timeout, ph_run ? 1'b0 : m_to);
    check("cycle_count", cycle_count, ph_run ? k - 1 : m_cnt);
    check("host_gnt", bus.host_gnt, gnt);
    check("ram_ren", bus.ram_ren, e_ren);
    check("ram_wen", bus.ram_wen, e_wen);
    check("ram_addr", bus.ram_addr, e_addr);
    check("ram_wdata", bus.ram_wdata, e_wdata);
    if (gnt && !bus.host_we && mv[bus.host_addr])
      check("host_rdata", bus.host_rdata, mm[bus.host_addr]);
    if (ph_run && bus.cpu_ren && mv[bus.cpu_addr])
      check("cpu_rdata", bus.cpu_rdata, mm[bus.cpu_addr]);
    if (rst_n) begin
      if (!m_active) begin
        if (gnt && bus.host_we) begin mm[bus.host_addr] = bus.host_wdata; mv[bus.host_addr] = 1; end
        if (go) begin m_active = 1; m_done = 0; m_t = 0; end
      end else begin
        if (ph_clr) begin
          mm[AW'(m_t)] = '0; mv[AW'(m_t)] = 1;
        end else if (!ph_run) begin
          m_cnt = 0; m_to = 0;  // START
        end else begin
          if (bus.cpu_wen) begin mm[bus.cpu_addr] = bus.cpu_wdata; mv[bus.cpu_addr] = 1; end
          if (bus.cpu_halt) begin
            m_cnt = k; m_to = 0; m_active = 0; m_done = 1;
          end else if (k == int'(TO)) begin
            m_cnt = k - 1; m_to = 1; m_active = 0; m_done = 1;
          end
        end
        m_t++;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic host_write(input logic [7:0] a, input logic [7:0] d);
    bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = a; bus.host_wdata = d;
    tick();
    bus.host_req = 1'b0; bus.host_we = 1'b0;
  endtask

  task automatic host_read_chk(input string nm, input logic [7:0] a, input logic [7:0] exp);
    bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = a;
    @(negedge clk);
    check({nm, "_gnt"}, bus.host_gnt, 1'b1);
    check(nm, bus.host_rdata, exp);
    tick();
    bus.host_req = 1'b0;
  endtask

  // Pulses go and waits for DONE; lat = edges from go to first RUN cycle, low = cycles with cpu_init low.
  task automatic run_prog(input int h_at, output int lat, output int low);
    halt_at = h_at;
    go = 1'b1;
    @(negedge clk);
    if (bus.host_req) check("go_beats_host_gnt", bus.host_gnt, 1'b0);
    tick();
    go = 1'b0;
    lat = 1;
    while (bus.cpu_init && lat < 400) begin tick(); lat++; end
    low = 0;
    while (!done && low < 100) begin
      if (!bus.cpu_init) low++;
      tick();
    end
    check("run_reached_done", done, 1'b1);
  endtask

  initial begin
    int lat, low, n;
    bus.host_req = 1'b0; bus.host_we = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_cpu_init", bus.cpu_init, 1'b1);
    check("rst_host_gnt", bus.host_gnt, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_cycle_count", cycle_count, 16'd0);
    tick();

    host_write(8'h10, 8'hA5);
    host_read_chk("rd_10", 8'h10, 8'hA5);
    host_write(8'h00, 8'hFF);
    host_write(8'hFF, 8'hFF);
    host_write(8'h02, 8'h00);
    cpu_force = 1'b1; tick(); tick(); cpu_force = 1'b0;
    host_read_chk("rd_02_cpu_wr_blocked", 8'h02, 8'h00);

    // run 1: halt on 5th RUN cycle with the host requesting throughout
    bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 8'h02;
    run_prog(5, lat, low);
    check("run1_latency", lat, LAT);
    check("run1_init_low", low, 5);
    check("run1_count", cycle_count, 16'd5);
    check("run1_timeout", timeout, 1'b0);
    @(negedge clk);
    check("run1_rd_02_gnt", bus.host_gnt, 1'b1);
    check("run1_rd_02", bus.host_rdata, 8'h3C);
    tick();
    bus.host_req = 1'b0;
    host_read_chk("rd_00", 8'h00, CLR ? 8'h00 : 8'hFF);
    host_read_chk("rd_ff", 8'hFF, CLR ? 8'h00 : 8'hFF);

    // run 2: no halt, watchdog stops after 20 RUN cycles
    run_prog(0, lat, low);
    check("run2_init_low", low, 20);
    check("run2_count", cycle_count, 16'd19);
    check("run2_timeout", timeout, 1'b1);

    // run 3: halt exactly on the watchdog cycle
    run_prog(20, lat, low);
    check("run3_count", cycle_count, 16'd20);
    check("run3_timeout", timeout, 1'b0);

    // run 4: go mid-run is ignored, then reset mid-run
    halt_at = 0;
    go = 1'b1; tick(); go = 1'b0;
    n = 0;
    while (bus.cpu_init && n < 400) begin tick(); n++; end
    repeat (3) tick();
    go = 1'b1; tick(); go = 1'b0;
    check("midrun_go_ignored", bus.cpu_init, 1'b0);
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    check("arst_cpu_init", bus.cpu_init, 1'b1);
    check("arst_done", done, 1'b0);
    check("arst_count", cycle_count, 16'd0);
    check("arst_ram_wen", bus.ram_wen, 1'b0);
    check("arst_busy", busy, 1'b0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    host_read_chk("rd_02_after_rst", 8'h02, 8'h3C);

    // run 5: clean run after reset
    run_prog(3, lat, low);
    check("run5_count", cycle_count, 16'd3);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end
endmodule
